apb_param_peripheral: RTL
=========================

# apb_param_peripheral

Parametrised APB slave register file: next generation of the team's fixed 32-bit APB peripheral, generalised in data width and register count. Adds configurable wait states, per-register read-only protection, latched transfer attributes and defined abort handling. It sits on the APB bus behind the bridge as a generic control/status register bank.

## Interface

- DATA_WIDTH, 32: register and bus data width; a multiple of 8.
- ADDR_WIDTH, 32: PADDR width.
- DEPTH, 16: number of registers. PADDR is a register index; valid range is 0..DEPTH-1.
- WAIT_STATES, 0: extra access-phase cycles inserted before PREADY; range 0..15.
- RO_MASK, {DEPTH{1'b0}}: bit i=1 makes register i read-only.
- RO_INIT, {DATA_WIDTH{1'b0}}: reset value of read-only registers.
- PCLK  in  1  clock; all logic on the rising edge.
- PRESET  in  1  reset; synchronous, active-high.
- PSEL  in  1  slave select.
- PENABLE  in  1  access phase.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  ADDR_WIDTH  register index.
- PWDATA  in  DATA_WIDTH  write data.
- PSTRB  in  DATA_WIDTH/8  byte write strobes; bit k enables PWDATA[8k+7:8k].
- PRDATA  out  DATA_WIDTH  read data; valid when PREADY=1 on a read.
- PREADY  out  1  transfer completion.
- PERROR  out  1  error response; valid only while PREADY=1.

## Operation

- FSM has two states. IDLE covers the APB idle and setup phases. ACCESS covers the access phase.
- IDLE to ACCESS: on the edge where PSEL=1 and PENABLE=0 (setup). On that edge the block:
  - latches PWRITE, PADDR, PWDATA and PSTRB;
  - clears the wait counter to 0;
  - sets the error flag to (PADDR >= DEPTH) or (PWRITE and RO_MASK[PADDR]);
  - loads PRDATA with mem[PADDR] on a valid read and with 0 otherwise.
- IDLE with PSEL=1 and PENABLE=1 is a protocol violation. The block ignores it and stays in IDLE with PREADY=0.
- In ACCESS, PREADY = (wait counter == WAIT_STATES). The counter increments each cycle while PREADY=0 and PSEL=1.
- Completion edge (ACCESS, PSEL=1, PENABLE=1, PREADY=1):
  - on a latched write with no error, each byte whose latched PSTRB bit is 1 is written into mem[latched PADDR];
  - the FSM returns to IDLE.
- Abort: PSEL=0 in ACCESS before completion returns the FSM to IDLE. No write occurs and PREADY never asserts.
- Error transfers complete normally with PERROR=1. Registers are unchanged and PRDATA=0.
- A write with PSTRB=0 to a writable valid register is a no-op with PERROR=0. A write with PSTRB=0 to a read-only register still errors.
- PADDR, PWDATA, PWRITE and PSTRB changes during ACCESS are ignored; only latched values are used.
- Read PSTRB is ignored.

## Timing

- Reset values:
  - FSM = IDLE;
  - PRDATA = 0, PREADY = 0, PERROR = 0;
  - wait counter = 0;
  - writable registers = 0;
  - read-only registers = RO_INIT.
- PRESET asserted mid-transfer aborts the transfer, with no write, and applies the reset values on that edge.
- PREADY and PERROR are decoded from registered state only; no input feeds them combinationally.
- Latency: the access phase lasts WAIT_STATES+1 cycles. A full transfer is setup + WAIT_STATES + 1 = WAIT_STATES+2 cycles.
- Write data is visible to a read whose setup edge comes after the completion edge.
- Back-to-back: after the completion edge the FSM is in IDLE. A setup cycle in the very next cycle is accepted, with no dead cycle.
- PERROR=0 whenever PREADY=0. PRDATA holds its value until the next setup edge or reset.

## Test plan

All scenarios use DATA_WIDTH=32, DEPTH=16, WAIT_STATES=2, RO_MASK=16'h8000, RO_INIT=32'hC0DE0001.

- Reset, then read index 3 -> PRDATA=0, PERROR=0. PREADY rises in the 3rd access cycle, with exactly 2 cycles of PREADY=0 before it.
- Write 32'hA5A5A5A5 to index 5 with PSTRB=4'b1100, then read index 5 -> PRDATA=32'hA5A50000, PERROR=0 on both transfers.
- Write to index 20 with PSTRB=4'b1111 -> PREADY=1 with PERROR=1. A following read of index 20 gives PRDATA=0, PERROR=1. All registers are unchanged.
- Write 32'hFFFFFFFF to index 15 -> PERROR=1. A read of index 15 returns 32'hC0DE0001 with PERROR=0.
- Abort: write 32'h12345678 to index 2, then drop PSEL in the 2nd access cycle -> PREADY stays 0. A read of index 2 returns 0. A change of PADDR during ACCESS of a valid transfer has no effect.
- Two back-to-back writes (indices 1 and 2), then PRESET asserted during the wait states of a write to index 1 with data 32'h0000BEEF -> after reset, reads of indices 1 and 2 return 0 and outputs hold their reset values.

Source files
------------

// File: rtl/apb_param_peripheral.sv
// APB slave register bank with configurable width, depth, wait states and
// per-register read-only protection. Transfer attributes are latched at setup.
module apb_param_peripheral #(
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           DEPTH       = 16,
  parameter int unsigned           WAIT_STATES = 0,
  parameter logic [DEPTH-1:0]      RO_MASK     = '0,
  parameter logic [DATA_WIDTH-1:0] RO_INIT     = '0
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PERROR
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned WAIT_W = 4;

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_write;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_W-1:0]     r_strb;
  logic                  r_err;
  logic [WAIT_W-1:0]     r_wait;
  logic                  r_ready;
  logic                  r_perror;
  logic [DATA_WIDTH-1:0] r_prdata;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic [IDX_W-1:0]      w_idx;
  logic                  w_addr_ok;
  logic                  w_err_new;
  logic                  w_err_cur;
  logic                  w_setup;
  logic                  w_complete;
  logic [WAIT_W-1:0]     w_wait_inc;
  logic [WAIT_W-1:0]     w_wait_nxt;
  logic                  w_ready_nxt;

  // Setup-time decode of the live bus address
  assign w_idx      = IDX_W'(PADDR);
  assign w_addr_ok  = (PADDR < ADDR_WIDTH'(DEPTH));
  assign w_err_new  = !w_addr_ok || (PWRITE && RO_MASK[w_idx]);
  assign w_err_cur  = w_setup ? w_err_new : r_err;
  assign w_wait_inc = r_wait + WAIT_W'(1);

  // Next-state and handshake decode
  always_comb begin
    w_state_nxt = r_state;
    w_setup     = 1'b0;
    w_complete  = 1'b0;
    w_wait_nxt  = r_wait;
    w_ready_nxt = r_ready;
    case (r_state)
      S_IDLE: begin
        if (PSEL && !PENABLE) begin
          w_setup     = 1'b1;
          w_state_nxt = S_ACCESS;
          w_wait_nxt  = '0;
          w_ready_nxt = (WAIT_STATES == 0);
        end
      end
      S_ACCESS: begin
        if (!PSEL) begin
          w_state_nxt = S_IDLE;
          w_ready_nxt = 1'b0;
        end else if (PENABLE && r_ready) begin
          w_complete  = 1'b1;
          w_state_nxt = S_IDLE;
          w_ready_nxt = 1'b0;
        end else if (!r_ready) begin
          w_wait_nxt  = w_wait_inc;
          w_ready_nxt = (w_wait_inc == WAIT_W'(WAIT_STATES));
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_ready_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Handshake, latched attributes and read data
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_idx    <= '0;
      r_write  <= 1'b0;
      r_wdata  <= '0;
      r_strb   <= '0;
      r_err    <= 1'b0;
      r_wait   <= '0;
      r_ready  <= 1'b0;
      r_perror <= 1'b0;
      r_prdata <= '0;
    end else begin
      r_wait   <= w_wait_nxt;
      r_ready  <= w_ready_nxt;
      r_perror <= w_ready_nxt && w_err_cur;
      if (w_setup) begin
        r_idx    <= w_idx;
        r_write  <= PWRITE;
        r_wdata  <= PWDATA;
        r_strb   <= PSTRB;
        r_err    <= w_err_new;
        r_prdata <= (w_addr_ok && !PWRITE) ? r_mem[w_idx] : '0;
      end
    end
  end

  // Register array; read-only entries are never written after reset
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= RO_MASK[i] ? RO_INIT : '0;
      end
    end else if (w_complete && r_write && !r_err) begin
      for (int k = 0; k < int'(STRB_W); k++) begin
        if (r_strb[k]) r_mem[r_idx][8*k +: 8] <= r_wdata[8*k +: 8];
      end
    end
  end

  assign PRDATA = r_prdata;
  assign PREADY = r_ready;
  assign PERROR = r_perror;

endmodule
